serial_sub_sequencer: RTL and testbench

//  Request/response front-end sitting directly upstream of the 32-bit serial subtractor.

---
 rtl/serial_sub_sequencer.sv | 255 +++++++++++++++++++++++++
 tb/tb_serial_sub_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_sequencer.sv
// serial_sub_sequencer
// Front-end for a 32-bit serial subtractor. Operand requests are queued in a
// DEPTH-entry FIFO and issued one at a time with a single-cycle start pulse.
// The subtractor result, borrow and derived zero/negative flags are returned
// on a valid/ready response port.
// Optional macro SEQ_TIMEOUT_EN: adds a watchdog that aborts an operation when
// the subtractor has not raised done within TIMEOUT busy cycles, returning an
// all-zero response with rsp_err set.
module serial_sub_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_a,
    input  logic [31:0]              req_b,
    input  logic                     req_bin,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_diff,
    output logic                     rsp_bout,
    output logic                     rsp_zero,
    output logic                     rsp_neg,
    output logic                     rsp_err,
    output logic                     sub_start,
    output logic [31:0]              sub_a,
    output logic [31:0]              sub_b,
    output logic                     sub_bin,
    input  logic [31:0]              sub_diff,
    input  logic                     sub_bout,
    input  logic                     sub_done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         state_r;
    state_t         state_s;

    logic [31:0]    mem_a_r   [DEPTH];
    logic [31:0]    mem_b_r   [DEPTH];
    logic           mem_bin_r [DEPTH];
    logic [PW-1:0]  wr_ptr_r;
    logic [PW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;

    logic [31:0]    sub_a_r;
    logic [31:0]    sub_b_r;
    logic           sub_bin_r;

    logic [31:0]    rsp_diff_r;
    logic           rsp_bout_r;
    logic           rsp_zero_r;
    logic           rsp_neg_r;
    logic           rsp_valid_r;

    logic           full_s;
    logic           push_s;
    logic           pop_s;
    logic           load_s;
    logic           capture_s;
    logic           timeout_s;

    // A full FIFO refuses pushes even when the same cycle pops an entry.
    assign full_s    = (count_r == FULL_LEVEL);
    assign push_s    = req_valid && !full_s;
    assign pop_s     = (state_r == ISSUE);
    assign load_s    = (state_r == IDLE) && (count_r != {CW{1'b0}});
    assign capture_s = (state_r == BUSY) && sub_done;

    // Request FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_r[i]   <= 32'd0;
                mem_b_r[i]   <= 32'd0;
                mem_bin_r[i] <= 1'b0;
            end
        end else begin
            if (push_s) begin
                mem_a_r[wr_ptr_r]   <= req_a;
                mem_b_r[wr_ptr_r]   <= req_b;
                mem_bin_r[wr_ptr_r] <= req_bin;
                wr_ptr_r            <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode: one operation in flight, response held until taken.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s = BUSY;
            end
            BUSY: begin
                if (capture_s || timeout_s) begin
                    state_s = RESP;
                end else begin
                    state_s = BUSY;
                end
            end
            RESP: begin
                if (rsp_valid_r && rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Subtractor operands: loaded from the FIFO head when leaving IDLE and
    // held stable through ISSUE and BUSY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_a_r   <= 32'd0;
            sub_b_r   <= 32'd0;
            sub_bin_r <= 1'b0;
        end else if (load_s) begin
            sub_a_r   <= mem_a_r[rd_ptr_r];
            sub_b_r   <= mem_b_r[rd_ptr_r];
            sub_bin_r <= mem_bin_r[rd_ptr_r];
        end else begin
            sub_a_r   <= sub_a_r;
            sub_b_r   <= sub_b_r;
            sub_bin_r <= sub_bin_r;
        end
    end

    // Response registers: capture on done (or watchdog abort), release on handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_diff_r  <= 32'd0;
            rsp_bout_r  <= 1'b0;
            rsp_zero_r  <= 1'b0;
            rsp_neg_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else if (capture_s) begin
            rsp_diff_r  <= sub_diff;
            rsp_bout_r  <= sub_bout;
            rsp_zero_r  <= (sub_diff == 32'd0);
            rsp_neg_r   <= sub_diff[31];
            rsp_valid_r <= 1'b1;
        end else if (timeout_s) begin
            rsp_diff_r  <= 32'd0;
            rsp_bout_r  <= 1'b0;
            rsp_zero_r  <= 1'b0;
            rsp_neg_r   <= 1'b0;
            rsp_valid_r <= 1'b1;
        end else if (rsp_valid_r && rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    logic [WW-1:0] wd_cnt_r;
    logic          rsp_err_r;

    // Watchdog counter: zeroed in ISSUE, counts each BUSY cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_r <= {WW{1'b0}};
        end else if (state_r == ISSUE) begin
            wd_cnt_r <= {WW{1'b0}};
        end else if (state_r == BUSY) begin
            wd_cnt_r <= wd_cnt_r + 1'b1;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    // The abort fires on the TIMEOUT-th busy cycle without done.
    assign timeout_s = (state_r == BUSY) && !sub_done && (wd_cnt_r == WD_LAST);

    // Error flag: set by an abort, cleared by the next genuine capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_err_r <= 1'b0;
        end else if (capture_s) begin
            rsp_err_r <= 1'b0;
        end else if (timeout_s) begin
            rsp_err_r <= 1'b1;
        end else begin
            rsp_err_r <= rsp_err_r;
        end
    end

    assign rsp_err = rsp_err_r;
`else
    assign timeout_s = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    assign req_ready  = !full_s;
    assign fifo_level = count_r;
    assign sub_start  = (state_r == ISSUE);
    assign busy       = (state_r != IDLE);
    assign sub_a      = sub_a_r;
    assign sub_b      = sub_b_r;
    assign sub_bin    = sub_bin_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_diff   = rsp_diff_r;
    assign rsp_bout   = rsp_bout_r;
    assign rsp_zero   = rsp_zero_r;
    assign rsp_neg    = rsp_neg_r;

endmodule

// File: tb/tb_serial_sub_sequencer.sv
// Testbench for serial_sub_sequencer: behavioural serial-subtractor stand-in,
// queue-based reference model, directed scenarios plus randomized bursts.
module tb_serial_sub_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        req_bin = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_diff;
    logic        rsp_bout;
    logic        rsp_zero;
    logic        rsp_neg;
    logic        rsp_err;
    logic        sub_start;
    logic [31:0] sub_a;
    logic [31:0] sub_b;
    logic        sub_bin;
    logic [31:0] sub_diff;
    logic        sub_bout;
    logic        sub_done;
    logic        busy;
    logic [$clog2(DEPTH):0] fifo_level;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
    } req_t;

    req_t exp_q[$];

    serial_sub_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_bin(req_bin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_diff(rsp_diff), .rsp_bout(rsp_bout), .rsp_zero(rsp_zero),
        .rsp_neg(rsp_neg), .rsp_err(rsp_err),
        .sub_start(sub_start), .sub_a(sub_a), .sub_b(sub_b), .sub_bin(sub_bin),
        .sub_diff(sub_diff), .sub_bout(sub_bout), .sub_done(sub_done),
        .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Serial subtractor stand-in: done clears on start, rises 33 edges later.
    logic        stall = 1'b0;
    logic        s_busy;
    logic [5:0]  s_cnt;
    logic [31:0] s_a;
    logic [31:0] s_b;
    logic        s_bin;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sub_done <= 1'b0;
            s_busy   <= 1'b0;
            s_cnt    <= 6'd0;
            sub_diff <= 32'd0;
            sub_bout <= 1'b0;
        end else if (sub_start) begin
            sub_done <= 1'b0;
            s_busy   <= 1'b1;
            s_cnt    <= 6'd0;
            s_a      <= sub_a;
            s_b      <= sub_b;
            s_bin    <= sub_bin;
        end else if (s_busy && !stall) begin
            s_cnt <= s_cnt + 6'd1;
            if (s_cnt == 6'd32) begin
                s_busy   <= 1'b0;
                sub_done <= 1'b1;
                {sub_bout, sub_diff} <= {1'b0, s_a} - {1'b0, s_b} - {32'd0, s_bin};
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
        check({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({pfx, "_rsp_diff"},  rsp_diff, 32'd0);
        check({pfx, "_rsp_flags"}, {28'd0, rsp_bout, rsp_zero, rsp_neg, rsp_err}, 32'd0);
        check({pfx, "_sub_start"}, 32'(sub_start), 32'd0);
        check({pfx, "_sub_ops"},   sub_a | sub_b | 32'(sub_bin), 32'd0);
        check({pfx, "_busy"},      32'(busy), 32'd0);
        check({pfx, "_level"},     32'(fifo_level), 32'd0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic bin);
        req_t r;
        bit   accepted = 1'b0;
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        req_bin = bin;
        for (int i = 0; i < 300 && !accepted; i++) begin
            if (req_ready) accepted = 1'b1;
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (accepted) begin
            r.a = a; r.b = b; r.bin = bin;
            exp_q.push_back(r);
        end else begin
            check("push_accept", 32'(req_ready), 32'd1);
        end
    endtask

    task automatic wait_valid(input int limit);
        for (int i = 0; i < limit && !rsp_valid; i++) @(negedge clk);
        check("rsp_valid_wait", 32'(rsp_valid), 32'd1);
    endtask

    // Waits for a response, checks it against the model, stalls, then takes it.
    task automatic get_rsp(input int stall_cycles);
        req_t        r;
        logic [32:0] wide;
        logic [31:0] ed;
        logic        eb;
        wait_valid(300);
        if (exp_q.size() == 0) begin
            check("model_queue_nonempty", 32'(exp_q.size()), 32'd1);
        end else begin
            r    = exp_q.pop_front();
            ed   = r.a - r.b - 32'(r.bin);
            wide = {1'b0, r.b} + 33'(r.bin);
            eb   = ({1'b0, r.a} < wide);
            check("rsp_diff", rsp_diff, ed);
            check("rsp_bout", 32'(rsp_bout), 32'(eb));
            check("rsp_zero", 32'(rsp_zero), 32'(ed == 32'd0));
            check("rsp_neg",  32'(rsp_neg),  32'(ed[31]));
            check("rsp_err",  32'(rsp_err),  32'd0);
            for (int i = 0; i < stall_cycles; i++) begin
                @(negedge clk);
                check("stall_valid", 32'(rsp_valid), 32'd1);
                check("stall_diff",  rsp_diff, ed);
                check("stall_bout",  32'(rsp_bout), 32'(eb));
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check("valid_after_take", 32'(rsp_valid), 32'd0);
        end
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int   starts;
        int   hits;
        bit   took;
        req_t r6;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        @(negedge clk);

        // 1: basic op with latency and start-pulse width
        push(32'd10, 32'd3, 1'b0);
        check("t1_level", 32'(fifo_level), 32'd1);
        check("t1_busy0", 32'(busy), 32'd0);
        starts = 0;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (sub_start) starts++;
            if (k == 1) begin
                check("t1_start_k1", 32'(sub_start), 32'd1);
                check("t1_sub_a", sub_a, 32'd10);
                check("t1_sub_b", sub_b, 32'd3);
            end
            if (k == 2) check("t1_level_popped", 32'(fifo_level), 32'd0);
            if (k == 35) check("t1_valid_k35", 32'(rsp_valid), 32'd0);
        end
        check("t1_valid_k36", 32'(rsp_valid), 32'd1);
        check("t1_start_count", 32'(starts), 32'd1);
        check("t1_diff_const", rsp_diff, 32'd7);
        get_rsp(2);

        // 2 and 3: negative, zero and borrow-in corners
        push(32'd3, 32'd10, 1'b0);
        wait_valid(100);
        check("t2_diff_const", rsp_diff, 32'hFFFF_FFF9);
        get_rsp(0);
        push(32'd5, 32'd5, 1'b0);
        wait_valid(100);
        check("t2_zero_const", 32'(rsp_zero), 32'd1);
        get_rsp(1);
        push(32'd0, 32'd0, 1'b1);
        wait_valid(100);
        check("t3_diff_const", rsp_diff, 32'hFFFF_FFFF);
        get_rsp(0);

        // 4: backpressure, FIFO fill and in-order drain
        for (int j = 0; j < 5; j++) push(32'(100 + j), 32'(j * 7), 1'(j & 1));
        check("t4_level_full", 32'(fifo_level), 32'd4);
        check("t4_ready_low", 32'(req_ready), 32'd0);
        r6.a = 32'h1234_5678; r6.b = 32'h0000_5678; r6.bin = 1'b1;
        req_valid = 1'b1; req_a = r6.a; req_b = r6.b; req_bin = r6.bin;
        wait_valid(100);
        check("t4_ready_in_resp", 32'(req_ready), 32'd0);
        check("t4_level_in_resp", 32'(fifo_level), 32'd4);
        get_rsp(3);
        took = 1'b0;
        for (int i = 0; i < 20 && !took; i++) begin
            if (req_ready) took = 1'b1;
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("t4_sixth_accepted", 32'(took), 32'd1);
        if (took) exp_q.push_back(r6);
        for (int j = 0; j < 5; j++) get_rsp(j % 3);
        check("t4_queue_drained", 32'(exp_q.size()), 32'd0);

        // 5: reset in the middle of BUSY
        push(32'd1, 32'd2, 1'b0);
        repeat (2) @(negedge clk);
        push(32'd7, 32'd8, 1'b0);
        push(32'd9, 32'd9, 1'b1);
        repeat (8) @(negedge clk);
        check("t5_busy_before", 32'(busy), 32'd1);
        check("t5_level_before", 32'(fifo_level), 32'd2);
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("t5_reset");
        reset = 1'b0;
        exp_q.delete();
        hits = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_valid || busy || (fifo_level != '0)) hits++;
        end
        check("t5_quiet_after_reset", 32'(hits), 32'd0);

        // Randomized bursts against the reference model
        for (int b = 0; b < 14; b++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) push(rand_word(), rand_word(), 1'($urandom_range(0, 1)));
            for (int j = 0; j < n; j++) get_rsp($urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        check("rand_queue_drained", 32'(exp_q.size()), 32'd0);

`ifdef SEQ_TIMEOUT_EN
        // 6: watchdog abort, then a clean operation clears the error
        stall = 1'b1;
        push(32'd50, 32'd20, 1'b0);
        for (int k = 1; k <= 66; k++) begin
            @(negedge clk);
            if (k == 65) check("t6_valid_k65", 32'(rsp_valid), 32'd0);
        end
        check("t6_valid_k66", 32'(rsp_valid), 32'd1);
        check("t6_err", 32'(rsp_err), 32'd1);
        check("t6_diff", rsp_diff, 32'd0);
        check("t6_flags", {29'd0, rsp_bout, rsp_zero, rsp_neg}, 32'd0);
        void'(exp_q.pop_front());
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        stall = 1'b0;
        push(32'd50, 32'd20, 1'b0);
        get_rsp(0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
